sap_datapath: RTL and testbench
===============================

Name: sap_datapath

Overview:
- Datapath consumer of the 15-bit control word produced by the sequencer: program counter, MAR, 16-entry RAM, instruction register, A/B registers, adder/subtractor and output register, all sharing one internal bus.
- Returns the current opcode to the sequencer and exposes the output register, a halt status and debug/flag signals.
- Includes a program-load port so the bench and board top can fill RAM before running.

Parameters:
- DATA_W, 8, bus/register/RAM word width; must be ≥ 4 + ADDR_W.
- ADDR_W, 4, PC/MAR/RAM address width; RAM depth = 2**ADDR_W.

Ports:
- clk  in  1  system clock; all datapath state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- ctrl  in  15  control word, MSB→LSB: hlt, pc_inc, pc_load, pc_en, mar_load, mem_st, mem_en, ir_load, ir_en, a_load, a_en, b_load, adder_sub, adder_en, out_load.
- prog_mode  in  1  1 = program-load mode; ctrl ignored.
- prog_we  in  1  RAM write strobe, valid only in prog_mode.
- prog_addr  in  ADDR_W  program-load address.
- prog_data  in  DATA_W  program-load data.
- opcode  out  4  IR[DATA_W-1:DATA_W-4], to sequencer.
- out_value  out  DATA_W  output register.
- out_valid  out  1  one-cycle pulse, cycle after out_value updates.
- halted  out  1  sticky halt.
- carry  out  1  carry flag.
- zero  out  1  zero flag.
- bus  out  DATA_W  internal bus (debug).
- bus_conflict  out  1  combinational; more than one bus driver, or mem_st with mem_en.

Behaviour:
- Reset (sync, rst=1 at posedge): PC, MAR, IR, A, B, out_value, carry, zero, halted, out_valid ← 0. RAM contents are not reset. Reset takes effect mid-instruction and overrides every other event in that cycle, including prog_we.
- Bus is combinational: OR of enabled sources.
  - pc_en → PC zero-extended.
  - mem_en → RAM[MAR] (asynchronous read).
  - ir_en → IR[ADDR_W-1:0] zero-extended.
  - a_en → A.
  - adder_en → sum.
  - No driver → bus = 0.
  - Two or more drivers → bus_conflict = 1; the bus still carries the OR of the sources.
- Adder: sum = A + B when adder_sub=0; A + ~B + 1 when adder_sub=1. Result is DATA_W bits with wrap; carry = carry-out of the DATA_W-bit add.
- Posedge updates when !rst, !prog_mode, !halted:
  - pc_load: PC ← bus[ADDR_W-1:0]. Else pc_inc: PC ← PC+1, wrapping 2**ADDR_W-1→0. pc_load wins if both are set.
  - mar_load: MAR ← bus[ADDR_W-1:0].
  - mem_st: RAM[MAR] ← bus. Suppressed if mem_en is also set (conflict flagged).
  - ir_load: IR ← bus.
  - a_load: A ← bus.
    - If adder_en is also set, carry ← adder carry and zero ← (sum==0).
    - Flags hold on all other cycles.
  - b_load: B ← bus.
  - out_load: out_value ← bus; out_valid = 1 on the following cycle only.
  - hlt: halted ← 1.
    - Loads asserted in the same ctrl word as hlt still complete that edge.
    - From the next edge, all ctrl effects are suppressed until rst.
- Read-before-write: a register that both drives and loads in one cycle (e.g. A with a_en & a_load) reloads its old value.
- prog_mode=1: ctrl fully ignored (no bus drive, no register updates, bus_conflict=0). prog_we writes RAM[prog_addr] ← prog_data at posedge. Leaving prog_mode does not reset PC; the bench asserts rst afterwards.
- halted does not block prog_mode RAM writes.
- opcode is combinational from IR.
- Latency:
  - A register load is visible one posedge after its ctrl bit is sampled.
  - out_valid lags out_value by one cycle.

Test Plan:
- Program RAM: [0]=0x1E (LDA 14), [1]=0x2F (ADD 15), [2]=0xE0 (OUT), [3]=0xF0 (HLT), [14]=28, [15]=14. Apply rst, then drive the six-stage control sequence → out_value=42 with a single out_valid pulse, carry=0, zero=0, halted=1; PC, A and out_value frozen thereafter.
- Subtract: A=5, B=7, adder_sub=1, adder_en=1, a_load=1 → A=0xFE, carry=0, zero=0. A=7, B=7 → A=0x00, carry=1, zero=1.
- Jump and wrap: PC=15 with pc_inc → PC=0. IR=0x6A, ir_en=1, pc_load=1, pc_inc=1 → PC=0xA.
- Store: A=0x5C, MAR=9, a_en=1, mem_st=1 → RAM[9]=0x5C. Same with mem_en=1 added → RAM[9] unchanged, bus_conflict=1.
- Conflict: pc_en=1 with a_en=1, PC=0x3, A=0x50 → bus=0x53, bus_conflict=1.
- Reset mid-op: rst=1 in the same cycle as a_load with bus=0x77 → A=0, halted=0, RAM unchanged; the previous program reruns correctly afterwards.

Source files
------------

// File: rtl/sap_datapath.sv
// sap_datapath: SAP-style datapath driven by a 15-bit control word.
// Holds PC, MAR, a 2**ADDR_W-word RAM, IR, A, B, adder/subtractor and the
// output register, all exchanging data over one OR-combined internal bus.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   ctrl          control word {hlt, pc_inc, pc_load, pc_en, mar_load, mem_st,
//                 mem_en, ir_load, ir_en, a_load, a_en, b_load, adder_sub,
//                 adder_en, out_load}
//   prog_mode     1 = RAM program-load mode, ctrl ignored
//   prog_we       RAM write strobe in program-load mode
//   prog_addr     program-load address
//   prog_data     program-load data
//   opcode        IR upper nibble, to the sequencer
//   out_value     output register
//   out_valid     one-cycle pulse, the cycle after out_value updates
//   halted        sticky halt status
//   carry, zero   adder flags, captured when A loads the adder result
//   bus           internal bus (debug)
//   bus_conflict  more than one bus driver, or mem_st together with mem_en
module sap_datapath #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [14:0]       ctrl,
   input  logic              prog_mode,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic [3:0]        opcode,
   output logic [DATA_W-1:0] out_value,
   output logic              out_valid,
   output logic              halted,
   output logic              carry,
   output logic              zero,
   output logic [DATA_W-1:0] bus,
   output logic              bus_conflict
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] mar;
   logic [DATA_W-1:0] ir;
   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] b_reg;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              out_pend;

   logic hlt, pc_inc, pc_load, pc_en, mar_load, mem_st, mem_en;
   logic ir_load, ir_en, a_load, a_en, b_load, adder_sub, adder_en, out_load;

   // In program-load mode the whole control word is masked, so nothing drives
   // the bus and no conflict can be reported.
   assign {hlt, pc_inc, pc_load, pc_en, mar_load, mem_st, mem_en,
           ir_load, ir_en, a_load, a_en, b_load, adder_sub, adder_en,
           out_load} = prog_mode ? 15'd0 : ctrl;

   logic [DATA_W-1:0] b_opnd;
   logic [DATA_W:0]   sum_full;
   logic [DATA_W-1:0] sum;

   // Subtraction is A + ~B + 1; carry is the raw carry-out of that add.
   assign b_opnd   = adder_sub ? ~b_reg : b_reg;
   assign sum_full = {1'b0, a_reg} + {1'b0, b_opnd} + {{DATA_W{1'b0}}, adder_sub};
   assign sum      = sum_full[DATA_W-1:0];

   logic [2:0] n_drv;

   always_comb begin
      bus = '0;
      if (pc_en)    bus = bus | {{(DATA_W-ADDR_W){1'b0}}, pc};
      if (mem_en)   bus = bus | mem[mar];
      if (ir_en)    bus = bus | {{(DATA_W-ADDR_W){1'b0}}, ir[ADDR_W-1:0]};
      if (a_en)     bus = bus | a_reg;
      if (adder_en) bus = bus | sum;
   end

   assign n_drv = {2'b00, pc_en} + {2'b00, mem_en} + {2'b00, ir_en}
                + {2'b00, a_en} + {2'b00, adder_en};
   assign bus_conflict = (n_drv > 3'd1) || (mem_st && mem_en);

   assign opcode = ir[DATA_W-1 -: 4];

   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= '0;
         mar       <= '0;
         ir        <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         out_value <= '0;
         out_pend  <= 1'b0;
         out_valid <= 1'b0;
         carry     <= 1'b0;
         zero      <= 1'b0;
         halted    <= 1'b0;
      end else begin
         // A pending output strobe already committed before a halt still fires.
         out_valid <= out_pend;
         out_pend  <= 1'b0;
         if (!halted) begin
            if (pc_load)     pc <= bus[ADDR_W-1:0];
            else if (pc_inc) pc <= pc + 1'b1;
            if (mar_load)    mar <= bus[ADDR_W-1:0];
            if (ir_load)     ir <= bus;
            if (a_load) begin
               a_reg <= bus;
               if (adder_en) begin
                  carry <= sum_full[DATA_W];
                  zero  <= (sum == '0);
               end
            end
            if (b_load)      b_reg <= bus;
            if (out_load) begin
               out_value <= bus;
               out_pend  <= 1'b1;
            end
            if (hlt)         halted <= 1'b1;
         end
      end
   end

   // RAM is never cleared; reset only blocks writes in its own cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (prog_mode) begin
            if (prog_we) mem[prog_addr] <= prog_data;
         end else if (!halted && mem_st && !mem_en) begin
            mem[mar] <= bus;
         end
      end
   end

endmodule

// File: tb/tb_sap_datapath.sv
// Scoreboard bench for sap_datapath: stimulus pushes expected values, a
// negedge monitor pops and compares them; out_valid pulses are matched
// against a separate queue of expected output values.
module tb_sap_datapath;

   localparam logic [14:0] HLT      = 15'h4000;
   localparam logic [14:0] PC_INC   = 15'h2000;
   localparam logic [14:0] PC_LOAD  = 15'h1000;
   localparam logic [14:0] PC_EN    = 15'h0800;
   localparam logic [14:0] MAR_LOAD = 15'h0400;
   localparam logic [14:0] MEM_ST   = 15'h0200;
   localparam logic [14:0] MEM_EN   = 15'h0100;
   localparam logic [14:0] IR_LOAD  = 15'h0080;
   localparam logic [14:0] IR_EN    = 15'h0040;
   localparam logic [14:0] A_LOAD   = 15'h0020;
   localparam logic [14:0] A_EN     = 15'h0010;
   localparam logic [14:0] B_LOAD   = 15'h0008;
   localparam logic [14:0] SUB      = 15'h0004;
   localparam logic [14:0] ADD_EN   = 15'h0002;
   localparam logic [14:0] OUT_LOAD = 15'h0001;

   localparam int S_BUS = 0, S_CONF = 1, S_OUT = 2, S_HALT = 3;
   localparam int S_CARRY = 4, S_ZERO = 5, S_OPC = 6, S_OVLD = 7;

   logic        clk = 1'b0;
   logic        rst;
   logic [14:0] ctrl;
   logic        prog_mode;
   logic        prog_we;
   logic [3:0]  prog_addr;
   logic [7:0]  prog_data;
   logic [3:0]  opcode;
   logic [7:0]  out_value;
   logic        out_valid;
   logic        halted;
   logic        carry;
   logic        zero;
   logic [7:0]  bus;
   logic        bus_conflict;

   sap_datapath #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .ctrl(ctrl), .prog_mode(prog_mode),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .opcode(opcode), .out_value(out_value), .out_valid(out_valid),
      .halted(halted), .carry(carry), .zero(zero), .bus(bus),
      .bus_conflict(bus_conflict)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          sel;
      logic [15:0] exp;
   } chk_t;

   chk_t        chk_q[$];
   logic [7:0]  out_q[$];
   int          tests = 0;
   int          fails = 0;
   logic [3:0]  cur_mar;

   function automatic logic [15:0] sample(input int sel);
      case (sel)
         S_BUS:   return 16'(bus);
         S_CONF:  return 16'(bus_conflict);
         S_OUT:   return 16'(out_value);
         S_HALT:  return 16'(halted);
         S_CARRY: return 16'(carry);
         S_ZERO:  return 16'(zero);
         S_OPC:   return 16'(opcode);
         default: return 16'(out_valid);
      endcase
   endfunction

   always @(negedge clk) begin
      chk_t e;
      logic [15:0] act;
      logic [7:0]  eo;
      while (chk_q.size() > 0) begin
         e = chk_q.pop_front();
         act = sample(e.sel);
         tests++;
         if (act !== e.exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, act, e.exp, $time);
         end
      end
      if (out_valid === 1'b1) begin
         tests++;
         if (out_q.size() == 0) begin
            fails++;
            $display("FAIL out_valid: got unexpected pulse (out_value 0x%0h) expected none at %0t",
                     out_value, $time);
         end else begin
            eo = out_q.pop_front();
            if (out_value !== eo) begin
               fails++;
               $display("FAIL out_value_pulse: got 0x%0h expected 0x%0h at %0t", out_value, eo, $time);
            end
         end
      end
   end

   task automatic chk(input string nm, input int sel, input logic [15:0] v);
      chk_q.push_back('{nm, sel, v});
   endtask

   task automatic cyc(input logic [14:0] c);
      ctrl = c;
      @(posedge clk);
      #1;
      ctrl = '0;
   endtask

   // ctrl is driven all-ones to show it is ignored while loading.
   task automatic prog_write(input logic [3:0] addr, input logic [7:0] data);
      prog_mode = 1'b1;
      prog_we   = 1'b1;
      prog_addr = addr;
      prog_data = data;
      ctrl      = '1;
      @(posedge clk);
      #1;
      prog_mode = 1'b0;
      prog_we   = 1'b0;
      ctrl      = '0;
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      ctrl = '0;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      cur_mar = 4'd0;
   endtask

   // Point MAR at k by routing a RAM word through IR (clobbers RAM[MAR] and IR).
   task automatic set_mar(input logic [3:0] k);
      prog_write(cur_mar, {4'h0, k});
      cyc(MEM_EN | IR_LOAD);
      cyc(IR_EN | MAR_LOAD);
      cur_mar = k;
   endtask

   task automatic load_a(input logic [7:0] v);
      set_mar(4'd12);
      prog_write(4'd12, v);
      cyc(MEM_EN | A_LOAD);
   endtask

   task automatic load_b(input logic [7:0] v);
      set_mar(4'd12);
      prog_write(4'd12, v);
      cyc(MEM_EN | B_LOAD);
   endtask

   task automatic fetch();
      cyc(PC_EN | MAR_LOAD);
      cyc(PC_INC);
      cyc(MEM_EN | IR_LOAD);
   endtask

   // Hand sequencing of LDA 14; ADD 15; OUT; HLT.
   task automatic run_prog(input logic [7:0] exp_out);
      fetch(); cyc(IR_EN | MAR_LOAD); cyc(MEM_EN | A_LOAD); cyc('0);
      fetch(); cyc(IR_EN | MAR_LOAD); cyc(MEM_EN | B_LOAD); cyc(ADD_EN | A_LOAD);
      fetch(); out_q.push_back(exp_out); cyc(A_EN | OUT_LOAD); cyc('0); cyc('0);
      fetch(); cyc(HLT); cyc('0); cyc('0);
      cur_mar = 4'd3;
   endtask

   task automatic load_program();
      prog_write(4'd0, 8'h1E);
      prog_write(4'd1, 8'h2F);
      prog_write(4'd2, 8'hE0);
      prog_write(4'd3, 8'hF0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; ctrl = '0; prog_mode = 1'b0; prog_we = 1'b0;
      prog_addr = '0; prog_data = '0; cur_mar = '0;
      @(posedge clk); #1;
      chk("rst_out_value", S_OUT, 0);
      chk("rst_halted", S_HALT, 0);
      chk("rst_carry", S_CARRY, 0);
      chk("rst_zero", S_ZERO, 0);
      chk("rst_out_valid", S_OVLD, 0);
      chk("rst_opcode", S_OPC, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_pc", S_BUS, 0);   cyc(PC_EN);
      chk("rst_a", S_BUS, 0);    cyc(A_EN);
      chk("idle_bus", S_BUS, 0); chk("idle_conf", S_CONF, 0); cyc('0);

      // Program and run
      chk("prog_bus", S_BUS, 0); chk("prog_conf", S_CONF, 0);
      load_program();
      prog_write(4'd14, 8'd28);
      prog_write(4'd15, 8'd14);
      do_reset();
      run_prog(8'd42);
      chk("run_halted", S_HALT, 1);
      chk("run_carry", S_CARRY, 0);
      chk("run_zero", S_ZERO, 0);
      chk("run_out", S_OUT, 42);
      chk("run_opcode", S_OPC, 4'hF);
      chk("run_ovld_low", S_OVLD, 0);
      cyc('0);
      cyc(PC_INC | OUT_LOAD | A_LOAD | ADD_EN | B_LOAD | IR_LOAD);
      chk("halt_pc", S_BUS, 4);   cyc(PC_EN);
      chk("halt_a", S_BUS, 42);   cyc(A_EN);
      chk("halt_out", S_OUT, 42); chk("halt_opcode", S_OPC, 4'hF); cyc('0);
      cyc('0);

      // Subtract
      do_reset();
      chk("unhalt", S_HALT, 0); cyc('0);
      load_a(8'd5);
      load_b(8'd7);
      chk("sub1_bus", S_BUS, 8'hFE); cyc(SUB | ADD_EN | A_LOAD);
      chk("sub1_a", S_BUS, 8'hFE); chk("sub1_carry", S_CARRY, 0); chk("sub1_zero", S_ZERO, 0);
      cyc(A_EN);
      load_a(8'd7);
      chk("sub2_bus", S_BUS, 8'h00); cyc(SUB | ADD_EN | A_LOAD);
      chk("sub2_a", S_BUS, 8'h00); chk("sub2_carry", S_CARRY, 1); chk("sub2_zero", S_ZERO, 1);
      cyc(A_EN);
      cyc(ADD_EN);
      load_a(8'h80);
      chk("hold_a", S_BUS, 8'h80); chk("hold_carry", S_CARRY, 1); chk("hold_zero", S_ZERO, 1);
      cyc(A_EN);

      // Jump and wrap
      load_a(8'h0F);
      cyc(A_EN | PC_LOAD);
      chk("pc15", S_BUS, 8'h0F); cyc(PC_EN);
      cyc(PC_INC);
      chk("pc_wrap", S_BUS, 8'h00); cyc(PC_EN);
      set_mar(4'd12);
      prog_write(4'd12, 8'h6A);
      cyc(MEM_EN | IR_LOAD);
      chk("jmp_opcode", S_OPC, 4'h6); chk("jmp_bus", S_BUS, 8'h0A);
      cyc(IR_EN | PC_LOAD | PC_INC);
      chk("jmp_pc", S_BUS, 8'h0A); cyc(PC_EN);

      // Store
      prog_write(4'd9, 8'h11);
      load_a(8'h5C);
      set_mar(4'd9);
      chk("st_bus", S_BUS, 8'h5C); chk("st_conf", S_CONF, 0); cyc(A_EN | MEM_ST);
      chk("st_ram", S_BUS, 8'h5C); cyc(MEM_EN);
      load_a(8'h23);
      set_mar(4'd9);
      prog_write(4'd9, 8'h5C);
      chk("stc_bus", S_BUS, 8'h7F); chk("stc_conf", S_CONF, 1);
      cyc(A_EN | MEM_ST | MEM_EN);
      chk("stc_ram", S_BUS, 8'h5C); cyc(MEM_EN);

      // Conflict
      load_a(8'h03);
      cyc(A_EN | PC_LOAD);
      load_a(8'h50);
      chk("one_drv_bus", S_BUS, 8'h03); chk("one_drv_conf", S_CONF, 0); cyc(PC_EN);
      chk("conf_bus", S_BUS, 8'h53); chk("conf_flag", S_CONF, 1); cyc(PC_EN | A_EN);

      // Reset mid-op
      set_mar(4'd12);
      prog_write(4'd12, 8'h77);
      rst = 1'b1; ctrl = MEM_EN | A_LOAD;
      chk("rstop_bus", S_BUS, 8'h77);
      @(posedge clk); #1;
      rst = 1'b0; ctrl = '0; cur_mar = 4'd0;
      chk("rstop_a", S_BUS, 8'h00); cyc(A_EN);
      cyc(HLT);
      chk("pre_rst_halted", S_HALT, 1); cyc('0);
      rst = 1'b1; prog_mode = 1'b1; prog_we = 1'b1; prog_addr = 4'd14; prog_data = 8'hAA;
      @(posedge clk); #1;
      rst = 1'b0; prog_mode = 1'b0; prog_we = 1'b0;
      chk("rst_clears_halt", S_HALT, 0); cyc('0);
      set_mar(4'd14);
      chk("rst_blocks_we", S_BUS, 8'd28); cyc(MEM_EN);

      // Rerun
      load_program();
      do_reset();
      run_prog(8'd42);
      chk("rerun_out", S_OUT, 42);
      chk("rerun_halted", S_HALT, 1);
      chk("rerun_carry", S_CARRY, 0);
      cyc('0);
      cyc('0);
      cyc('0);

      tests++;
      if (out_q.size() != 0) begin
         fails++;
         $display("FAIL out_q_drained: got %0d pending expected 0", out_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
